dmem_responder: RTL and testbench

- Data-memory slave for the RV32I core's load/store bus.
- Accepts address, write data, wrEn/rdEn and the 4-bit RamMode {byte, half, word, unsigned} from the core.
- Performs byte-lane writes into a word-organised synchronous RAM and returns aligned, sign- or zero-extended load data one cycle later.
- Also detects illegal accesses and keeps error status for debug.

---
 rtl/dmem_responder_if.sv | 26 ++
 rtl/dmem_responder.sv | 113 +++++++++++
 tb/tb_dmem_responder.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - load/store bus between the core and the data-memory responder
interface dmem_responder_if #(
    parameter int ERR_CNT_W = 16
);
    logic                 clkEn;
    logic [31:0]          addr;
    logic [31:0]          wrData;
    logic                 wrEn;
    logic                 rdEn;
    logic [3:0]           RamMode;
    logic [31:0]          rdData;
    logic                 rdDataValid;
    logic                 accessErr;
    logic [31:0]          errAddr;
    logic [ERR_CNT_W-1:0] errCount;

    modport master (
        output clkEn, addr, wrData, wrEn, rdEn, RamMode,
        input  rdData, rdDataValid, accessErr, errAddr, errCount
    );

    modport slave (
        input  clkEn, addr, wrData, wrEn, rdEn, RamMode,
        output rdData, rdDataValid, accessErr, errAddr, errCount
    );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - byte-lane data RAM slave with extended loads and illegal-access status
module dmem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          ERR_CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rstB,
    dmem_responder_if.slave  bus
);
    localparam int          AW    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]   offset;
    logic [AW-1:0] wordIdx;
    logic [1:0]    lane;
    logic          accept, illegal, alignOk, rangeOk;
    logic [3:0]    byteEn;
    logic [31:0]   wrLanes;

    assign offset  = bus.addr - BASE_ADDR;
    assign wordIdx = offset[AW+1:2];
    assign lane    = offset[1:0];
    assign accept  = rstB & bus.clkEn & (bus.wrEn | bus.rdEn);
    assign alignOk = !(bus.RamMode[2] & lane[0]) && !(bus.RamMode[1] && lane != 2'd0);
    assign rangeOk = (bus.addr >= BASE_ADDR) && ({1'b0, offset} < LIMIT);
    assign illegal = (bus.wrEn & bus.rdEn) | !$onehot(bus.RamMode[3:1]) | !alignOk | !rangeOk;

    // Replicate store data so every lane sees its slice; byteEn picks which lanes land.
    always_comb begin
        byteEn  = 4'b1111;
        wrLanes = bus.wrData;
        if (bus.RamMode[3]) begin
            byteEn       = 4'b0000;
            byteEn[lane] = 1'b1;
            wrLanes      = {4{bus.wrData[7:0]}};
        end else if (bus.RamMode[2]) begin
            byteEn  = lane[1] ? 4'b1100 : 4'b0011;
            wrLanes = {2{bus.wrData[15:0]}};
        end
    end

    logic [31:0] rdWord;

    always_ff @(posedge clk) begin
        if (accept && !illegal && bus.wrEn) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) mem[wordIdx][8*i +: 8] <= wrLanes[8*i +: 8];
            end
        end
        rdWord <= mem[wordIdx];
    end

    // Response stage: what was accepted at the previous edge.
    logic        rdPend, errPend, errRdPend, sticky;
    logic [1:0]  rdLane;
    logic        rdByte, rdHalf, rdUns;
    logic [31:0] errAddrPend;
    logic [7:0]  selB;
    logic [15:0] selH;
    logic [31:0] loadExt;

    always_comb begin
        selB    = rdWord[8*rdLane +: 8];
        selH    = rdLane[1] ? rdWord[31:16] : rdWord[15:0];
        loadExt = rdWord;
        if (rdByte)      loadExt = {{24{!rdUns & selB[7]}}, selB};
        else if (rdHalf) loadExt = {{16{!rdUns & selH[15]}}, selH};
    end

    always_ff @(posedge clk) begin
        if (!rstB) begin
            rdPend          <= 1'b0;
            errPend         <= 1'b0;
            errRdPend       <= 1'b0;
            sticky          <= 1'b0;
            rdLane          <= 2'd0;
            rdByte          <= 1'b0;
            rdHalf          <= 1'b0;
            rdUns           <= 1'b0;
            errAddrPend     <= 32'd0;
            bus.rdData      <= 32'd0;
            bus.rdDataValid <= 1'b0;
            bus.accessErr   <= 1'b0;
            bus.errAddr     <= 32'd0;
            bus.errCount    <= '0;
        end else begin
            rdPend      <= accept & !illegal & bus.rdEn;
            errPend     <= accept & illegal;
            errRdPend   <= accept & illegal & bus.rdEn & !bus.wrEn;
            rdLane      <= lane;
            rdByte      <= bus.RamMode[3];
            rdHalf      <= bus.RamMode[2];
            rdUns       <= bus.RamMode[0];
            errAddrPend <= bus.addr;

            bus.rdDataValid <= rdPend | errRdPend;
            bus.accessErr   <= errPend;
            if (rdPend)         bus.rdData <= loadExt;
            else if (errRdPend) bus.rdData <= 32'd0;

            if (errPend) begin
                if (bus.errCount != '1) bus.errCount <= bus.errCount + ERR_CNT_W'(1);
                if (!sticky) begin
                    bus.errAddr <= errAddrPend;
                    sticky      <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - table vectors, corner sequences and randomized model check for dmem_responder
module tb_dmem_responder;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 64;
    localparam int          BYTES = 4 * DEPTH;
    localparam logic [3:0]  M_W = 4'b0010, M_H = 4'b0100, M_HU = 4'b0101, M_B = 4'b1000, M_BU = 4'b1001;

    logic clk = 1'b0;
    logic rstB;
    always #5 clk = ~clk;

    dmem_responder_if #(.ERR_CNT_W(16)) bus ();

    dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .ERR_CNT_W(16)) dut (
        .clk (clk),
        .rstB(rstB),
        .bus (bus)
    );

    int nVec = 0;
    int nErr = 0;

    typedef struct {
        logic        en, wr, rd;
        logic [3:0]  mode;
        logic [31:0] addr, data;
        logic        expValid, expErr;
        logic [31:0] expData, expErrAddr;
        int          expCnt;
    } vec_t;

    typedef struct {
        logic        valid, err;
        logic [31:0] data, errAddr;
        int          cnt;
    } exp_t;

    vec_t vecs[$];

    logic [7:0]  memModel [BYTES];
    int          mCnt;
    logic [31:0] mAddr, mLast;
    bit          mSticky;
    exp_t        expPrev;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic checkOut(input string nm, input exp_t e);
        check({nm, "_valid"}, 32'(bus.rdDataValid), 32'(e.valid));
        check({nm, "_err"}, 32'(bus.accessErr), 32'(e.err));
        check({nm, "_data"}, bus.rdData, e.data);
        check({nm, "_cnt"}, 32'(bus.errCount), 32'(e.cnt));
        check({nm, "_eaddr"}, bus.errAddr, e.errAddr);
    endtask

    task automatic drive(input logic en, wr, rd, input logic [3:0] mode, input logic [31:0] a, d);
        bus.clkEn   = en;
        bus.wrEn    = wr;
        bus.rdEn    = rd;
        bus.RamMode = mode;
        bus.addr    = a;
        bus.wrData  = d;
    endtask

    function automatic vec_t mk(input logic en, wr, rd, input logic [3:0] mode, input logic [31:0] a, d,
                                input logic ev, ee, input logic [31:0] ed, ea, input int ec);
        vec_t v;
        v.en = en; v.wr = wr; v.rd = rd; v.mode = mode; v.addr = a; v.data = d;
        v.expValid = ev; v.expErr = ee; v.expData = ed; v.expErrAddr = ea; v.expCnt = ec;
        return v;
    endfunction

    task automatic applyVec(input vec_t v, input int idx);
        exp_t e;
        @(negedge clk);
        drive(v.en, v.wr, v.rd, v.mode, v.addr, v.data);
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, M_W, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        e.valid = v.expValid; e.err = v.expErr; e.data = v.expData; e.errAddr = v.expErrAddr; e.cnt = v.expCnt;
        checkOut($sformatf("vec%0d", idx), e);
        @(posedge clk);
        #1;
        check($sformatf("vec%0d_pulse_valid", idx), 32'(bus.rdDataValid), 32'd0);
        check($sformatf("vec%0d_pulse_err", idx), 32'(bus.accessErr), 32'd0);
    endtask

    // Reference model: byte-addressed memory and plain arithmetic on offsets and sizes.
    function automatic logic [31:0] loadVal(input int off, input int size, input bit uns);
        longint v = 0;
        longint one = 1;
        for (int k = 0; k < size; k++) v += longint'(memModel[off + k]) << (8 * k);
        if (!uns && size < 4 && v >= (one << (8 * size - 1))) v -= (one << (8 * size));
        return v[31:0];
    endfunction

    task automatic modelReq(input logic en, wr, rd, input logic [3:0] mode, input logic [31:0] a, d,
                            output exp_t e);
        longint off;
        int     size;
        bit     bad;
        e.valid = 1'b0;
        e.err   = 1'b0;
        if (en && (wr || rd)) begin
            off  = longint'(a) - longint'(BASE);
            size = mode[3] ? 1 : (mode[2] ? 2 : 4);
            bad  = (wr && rd) || ($countones(mode[3:1]) != 1) || off < 0 || off >= BYTES || (off % size != 0);
            if (bad) begin
                e.err = 1'b1;
                if (rd && !wr) begin
                    e.valid = 1'b1;
                    mLast   = 32'd0;
                end
                if (mCnt < 65535) mCnt++;
                if (!mSticky) begin
                    mAddr   = a;
                    mSticky = 1'b1;
                end
            end else if (wr) begin
                for (int k = 0; k < size; k++) memModel[int'(off) + k] = d[8*k +: 8];
            end else begin
                mLast   = loadVal(int'(off), size, mode[0]);
                e.valid = 1'b1;
            end
        end
        e.data = mLast; e.cnt = mCnt; e.errAddr = mAddr;
    endtask

    task automatic step(input logic en, wr, rd, input logic [3:0] mode, input logic [31:0] a, d);
        exp_t e;
        @(negedge clk);
        drive(en, wr, rd, mode, a, d);
        modelReq(en, wr, rd, mode, a, d, e);
        @(posedge clk);
        #1;
        checkOut("rnd", expPrev);
        expPrev = e;
    endtask

    initial begin
        logic [3:0]  legal [6];
        logic [3:0]  mode;
        logic [31:0] a;
        int          r, kind, size;
        logic        en, wr, rd;

        legal[0] = M_W; legal[1] = M_H; legal[2] = M_HU;
        legal[3] = M_B; legal[4] = M_BU; legal[5] = 4'b0011;

        rstB = 1'b0;
        drive(1'b0, 1'b0, 1'b0, M_W, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.rdDataValid), 32'd0);
        check("rst_err", 32'(bus.accessErr), 32'd0);
        check("rst_data", bus.rdData, 32'd0);
        check("rst_cnt", 32'(bus.errCount), 32'd0);
        check("rst_eaddr", bus.errAddr, 32'd0);
        @(negedge clk);
        rstB = 1'b1;

        //           en    wr    rd    mode     addr          data          v     e     data          errAddr       cnt
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, M_W,    BASE+32'h00,  32'hCAFEF00D, 1'b0, 1'b0, 32'h00000000, 32'h0,        0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, M_W,    BASE+32'h10,  32'hDEADBEEF, 1'b0, 1'b0, 32'h00000000, 32'h0,        0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, M_W,    BASE+32'h10,  32'h0,        1'b1, 1'b0, 32'hDEADBEEF, 32'h0,        0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, M_B,    BASE+32'h13,  32'h0,        1'b1, 1'b0, 32'hFFFFFFDE, 32'h0,        0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, M_BU,   BASE+32'h13,  32'h0,        1'b1, 1'b0, 32'h000000DE, 32'h0,        0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, M_H,    BASE+32'h10,  32'h0,        1'b1, 1'b0, 32'hFFFFBEEF, 32'h0,        0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, M_B,    BASE+32'h11,  32'hAAAAAA55, 1'b0, 1'b0, 32'hFFFFBEEF, 32'h0,        0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, M_W,    BASE+32'h10,  32'h0,        1'b1, 1'b0, 32'hDEAD55EF, 32'h0,        0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, M_HU,   BASE+32'h12,  32'h0,        1'b1, 1'b0, 32'h0000DEAD, 32'h0,        0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, M_W,    BASE+32'h12,  32'h0,        1'b1, 1'b1, 32'h00000000, BASE+32'h12,  1));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, M_H,    BASE+32'h15,  32'h0,        1'b1, 1'b1, 32'h00000000, BASE+32'h12,  2));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, M_W,    BASE+BYTES,   32'h11111111, 1'b0, 1'b1, 32'h00000000, BASE+32'h12,  3));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 4'b0000,BASE+32'h10,  32'h0,        1'b0, 1'b1, 32'h00000000, BASE+32'h12,  4));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, M_W,    BASE+32'h10,  32'h0,        1'b0, 1'b1, 32'h00000000, BASE+32'h12,  5));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 4'b1010,BASE+32'h10,  32'h0,        1'b1, 1'b1, 32'h00000000, BASE+32'h12,  6));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, M_W,    BASE-32'h4,   32'h0,        1'b1, 1'b1, 32'h00000000, BASE+32'h12,  7));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, M_H,    BASE+32'h11,  32'h0000FFFF, 1'b0, 1'b1, 32'h00000000, BASE+32'h12,  8));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, M_W,    BASE+32'h10,  32'h0,        1'b1, 1'b0, 32'hDEAD55EF, BASE+32'h12,  8));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, M_W,    BASE+32'h00,  32'h0,        1'b1, 1'b0, 32'hCAFEF00D, BASE+32'h12,  8));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, M_W,    BASE+32'h10,  32'h0,        1'b0, 1'b0, 32'hCAFEF00D, BASE+32'h12,  8));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, M_W,    BASE+32'hFC,  32'h80000001, 1'b0, 1'b0, 32'hCAFEF00D, BASE+32'h12,  8));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, M_B,    BASE+32'hFF,  32'h0,        1'b1, 1'b0, 32'hFFFFFF80, BASE+32'h12,  8));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, M_HU,   BASE+32'hFE,  32'h0,        1'b1, 1'b0, 32'h00008000, BASE+32'h12,  8));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, M_H,    BASE+32'hFC,  32'h0,        1'b1, 1'b0, 32'h00000001, BASE+32'h12,  8));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, M_H,    BASE+32'hFE,  32'h1234ABCD, 1'b0, 1'b0, 32'h00000001, BASE+32'h12,  8));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, M_W,    BASE+32'hFC,  32'h0,        1'b1, 1'b0, 32'hABCD0001, BASE+32'h12,  8));

        for (int i = 0; i < vecs.size(); i++) applyVec(vecs[i], i);

        // Reset lands on the edge that would have delivered an accepted read.
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, M_W, BASE + 32'h10, 32'd0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, M_W, 32'd0, 32'd0);
        rstB = 1'b0;
        @(posedge clk);
        #1;
        check("rstfly_valid", 32'(bus.rdDataValid), 32'd0);
        check("rstfly_err", 32'(bus.accessErr), 32'd0);
        check("rstfly_data", bus.rdData, 32'd0);
        check("rstfly_cnt", 32'(bus.errCount), 32'd0);
        check("rstfly_eaddr", bus.errAddr, 32'd0);
        @(negedge clk);
        rstB = 1'b1;
        @(posedge clk);
        #1;
        check("rstfly_after_valid", 32'(bus.rdDataValid), 32'd0);

        mCnt = 0; mAddr = 32'd0; mLast = 32'd0; mSticky = 1'b0;
        expPrev.valid = 1'b0; expPrev.err = 1'b0; expPrev.data = 32'd0; expPrev.errAddr = 32'd0; expPrev.cnt = 0;

        for (int w = 0; w < DEPTH; w++) step(1'b1, 1'b1, 1'b0, M_W, BASE + 32'(4 * w), $urandom);

        for (int i = 0; i < 600; i++) begin
            en   = ($urandom_range(0, 9) != 0);
            kind = $urandom_range(0, 9);
            wr   = (kind >= 4 && kind <= 8);
            rd   = (kind < 4 || kind == 8);
            r    = $urandom_range(0, 7);
            mode = (r == 6) ? 4'($urandom_range(0, 15)) : legal[$urandom_range(0, 5)];
            size = mode[3] ? 1 : (mode[2] ? 2 : 4);
            r    = $urandom_range(0, 15);
            if (r == 0)      a = BASE + BYTES + 32'($urandom_range(0, 15));
            else if (r == 1) a = BASE - 32'($urandom_range(1, 16));
            else begin
                a = BASE + 32'($urandom_range(0, BYTES - 1));
                if (r < 12) a = a - 32'((a - BASE) % size);
            end
            step(en, wr, rd, mode, a, $urandom);
        end
        step(1'b0, 1'b0, 1'b0, M_W, 32'd0, 32'd0);
        step(1'b0, 1'b0, 1'b0, M_W, 32'd0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
